// File: rtl/axi4_master_burst_engine_if.sv
// AXI4 AW/W/B/AR/R bundle between the burst engine (master) and the slave under test.
interface axi4_master_burst_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) ();
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid, arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_master_burst_engine.sv
// Command-driven AXI4 master: AW/AR registers, W length FIFO, per-ID read tracking, one completion per command.
// Define AXI4_MST_ENGINE_TIMEOUT_EN to build the per-channel watchdog behind timeout_err.
module axi4_master_burst_engine #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                    aclk,
  input  logic                    areset,
  axi4_master_burst_engine_if.master axi,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]              rd_resp,
  output logic [ID_WIDTH-1:0]     rd_id,
  output logic                    rd_last,
  output logic                    done_valid,
  output logic                    done_write,
  output logic [ID_WIDTH-1:0]     done_id,
  output logic [1:0]              done_resp,
  output logic                    done_err,
  output logic [3:0]              timeout_err
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {W_IDLE, W_BEAT} w_st_t;
  typedef struct packed {
    logic                vld;
    logic [ID_WIDTH-1:0] id;
    logic [7:0]          len;
    logic [7:0]          cnt;
    logic [1:0]          worst;
  } rd_ent_t;

  rd_ent_t       tbl [MAX_OUTSTANDING];
  logic [7:0]    lfifo [MAX_OUTSTANDING];
  logic [PW:0]   wp, rp;
  w_st_t         wst;
  logic [7:0]    wlen, wcnt;
  logic          run, skid_full, skid_err;
  logic [ID_WIDTH-1:0] skid_id;
  logic [1:0]    skid_resp;
  logic [CW-1:0] inflight;

  logic          id_busy, hit, fifo_full, cmd_acc, b_hs, r_hs, r_final, r_err, r_done, w_last;
  logic [PW-1:0] hit_idx, free_idx;
  logic [1:0]    r_resp;

  always_comb begin
    id_busy  = 1'b0;
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (tbl[i].vld && tbl[i].id == cmd_id) id_busy = 1'b1;
      if (tbl[i].vld && tbl[i].id == axi.rid) begin hit = 1'b1; hit_idx = PW'(i); end
      if (!tbl[i].vld) free_idx = PW'(i);
    end
  end

  assign fifo_full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  // An address register being drained by awready/arready this cycle counts as free.
  assign cmd_ready = run && (inflight < CW'(MAX_OUTSTANDING)) &&
                     (cmd_write ? ((!axi.awvalid || axi.awready) && !fifo_full)
                                : ((!axi.arvalid || axi.arready) && !id_busy));
  assign cmd_acc   = cmd_valid && cmd_ready;

  assign axi.bready = run && !skid_full;
  assign axi.rready = run && rd_ready && !skid_full;
  assign b_hs       = axi.bvalid && axi.bready;
  assign r_hs       = axi.rvalid && axi.rready;
  assign rd_valid   = run && !skid_full && axi.rvalid;
  assign rd_data    = run ? axi.rdata : '0;
  assign rd_resp    = run ? axi.rresp : '0;
  assign rd_id      = run ? axi.rid   : '0;
  assign rd_last    = run && axi.rlast;

  // A beat with no matching entry is reported on its own as an error completion.
  assign r_final = !hit || axi.rlast || (tbl[hit_idx].cnt == tbl[hit_idx].len);
  assign r_err   = !hit || !(axi.rlast && (tbl[hit_idx].cnt == tbl[hit_idx].len));
  assign r_resp  = (hit && tbl[hit_idx].worst > axi.rresp) ? tbl[hit_idx].worst : axi.rresp;
  assign r_done  = r_hs && r_final;

  assign w_last    = (wst == W_BEAT) && (wcnt == wlen);
  assign axi.wvalid = (wst == W_BEAT) && wr_valid;
  assign wr_ready  = (wst == W_BEAT) && axi.wready;
  assign axi.wdata = (wst == W_BEAT) ? wr_data : '0;
  assign axi.wstrb = (wst == W_BEAT) ? wr_strb : '0;
  assign axi.wlast = w_last;

  always_ff @(posedge aclk) begin
    if (areset) begin
      run <= 1'b0; inflight <= '0;
      axi.awvalid <= 1'b0; axi.awid <= '0; axi.awaddr <= '0; axi.awlen <= '0; axi.awsize <= '0; axi.awburst <= '0;
      axi.arvalid <= 1'b0; axi.arid <= '0; axi.araddr <= '0; axi.arlen <= '0; axi.arsize <= '0; axi.arburst <= '0;
      wp <= '0; rp <= '0; wst <= W_IDLE; wlen <= '0; wcnt <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin tbl[i] <= '0; lfifo[i] <= '0; end
      skid_full <= 1'b0; skid_id <= '0; skid_resp <= '0; skid_err <= 1'b0;
      done_valid <= 1'b0; done_write <= 1'b0; done_id <= '0; done_resp <= '0; done_err <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= inflight + CW'(cmd_acc) - CW'(b_hs) - CW'(r_done && hit);

      if (cmd_acc && cmd_write) begin
        axi.awvalid <= 1'b1; axi.awid <= cmd_id; axi.awaddr <= cmd_addr;
        axi.awlen <= cmd_len; axi.awsize <= cmd_size; axi.awburst <= cmd_burst;
        lfifo[wp[PW-1:0]] <= cmd_len;
        wp <= wp + 1'b1;
      end else if (axi.awready) axi.awvalid <= 1'b0;

      if (cmd_acc && !cmd_write) begin
        axi.arvalid <= 1'b1; axi.arid <= cmd_id; axi.araddr <= cmd_addr;
        axi.arlen <= cmd_len; axi.arsize <= cmd_size; axi.arburst <= cmd_burst;
        tbl[free_idx] <= '{vld: 1'b1, id: cmd_id, len: cmd_len, cnt: 8'd0, worst: 2'd0};
      end else if (axi.arready) axi.arvalid <= 1'b0;

      case (wst)
        W_IDLE: if (wp != rp) begin
          wlen <= lfifo[rp[PW-1:0]]; rp <= rp + 1'b1; wcnt <= '0; wst <= W_BEAT;
        end
        W_BEAT: if (wr_valid && axi.wready) begin
          if (w_last) wst <= W_IDLE;
          else        wcnt <= wcnt + 1'b1;
        end
        default: wst <= W_IDLE;
      endcase

      if (r_hs && hit) begin
        if (r_final) tbl[hit_idx].vld <= 1'b0;
        else begin
          tbl[hit_idx].cnt   <= tbl[hit_idx].cnt + 1'b1;
          tbl[hit_idx].worst <= r_resp;
        end
      end

      // Skid drains first; B wins over a coincident final R, which parks in the skid.
      done_valid <= skid_full || b_hs || r_done;
      if (skid_full) begin
        skid_full <= 1'b0;
        done_write <= 1'b0; done_id <= skid_id; done_resp <= skid_resp; done_err <= skid_err;
      end else if (b_hs) begin
        done_write <= 1'b1; done_id <= axi.bid; done_resp <= axi.bresp; done_err <= 1'b0;
        if (r_done) begin
          skid_full <= 1'b1; skid_id <= axi.rid; skid_resp <= r_resp; skid_err <= r_err;
        end
      end else if (r_done) begin
        done_write <= 1'b0; done_id <= axi.rid; done_resp <= r_resp; done_err <= r_err;
      end
    end
  end

`ifdef AXI4_MST_ENGINE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [3:0]         to_cond, to_err;
  logic [3:0][TW-1:0] to_cnt;

  assign to_cond = {(inflight != '0) && !b_hs && !r_hs,
                    axi.arvalid && !axi.arready,
                    axi.wvalid && !axi.wready,
                    axi.awvalid && !axi.awready};

  always_ff @(posedge aclk) begin
    if (areset) begin
      to_cnt <= '0; to_err <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!to_cond[i])                           to_cnt[i] <= '0;
        else if (to_cnt[i] == TW'(TIMEOUT_CYCLES - 1)) to_err[i] <= 1'b1;
        else                                       to_cnt[i] <= to_cnt[i] + 1'b1;
      end
    end
  end
  assign timeout_err = to_err;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err = 4'b0;
`endif
endmodule

// File: tb/tb_axi4_master_burst_engine.sv
// Directed bench for axi4_master_burst_engine: the bench plays the AXI slave and checks hand-computed completions.
module tb_axi4_master_burst_engine;
  logic        aclk = 1'b0, areset = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [3:0]  rd_id;
  logic        done_valid, done_write, done_err;
  logic [3:0]  done_id;
  logic [1:0]  done_resp;
  logic [3:0]  timeout_err;
  int          total = 0, bad = 0, n, b;

  axi4_master_burst_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

  axi4_master_burst_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4),
                             .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(1000)) dut (
    .aclk(aclk), .areset(areset), .axi(axi),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
    .rd_id(rd_id), .rd_last(rd_last),
    .done_valid(done_valid), .done_write(done_write), .done_id(done_id),
    .done_resp(done_resp), .done_err(done_err), .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_done(input string tag, input logic w, input logic [3:0] id,
                          input logic [1:0] resp, input logic err);
    chk(tag, {done_valid, done_write, done_id, done_resp, done_err}, {1'b1, w, id, resp, err});
  endtask

  task automatic send_cmd(input logic w, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int k = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_id = id; cmd_addr = addr;
    cmd_len = len; cmd_size = 3'd2; cmd_burst = 2'b01;
    #1;
    while (!cmd_ready && k < 20) begin @(negedge aclk); #1; k++; end
    chk("cmd_accept", 64'(k < 20), 64'd1);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
    axi.rvalid = 1'b1; axi.rid = id; axi.rdata = d; axi.rresp = resp; axi.rlast = last;
    #1 chk("rd_fwd", {rd_valid, rd_id, rd_data, rd_resp, rd_last, axi.rready}, {1'b1, id, d, resp, last, 1'b1});
    @(negedge aclk);
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    wr_valid = 1'b1; wr_data = '0; wr_strb = '1; rd_ready = 1'b1;
    axi.awready = 1'b0; axi.wready = 1'b1; axi.arready = 1'b0;
    axi.bvalid = 1'b1; axi.bid = '0; axi.bresp = '0;
    axi.rvalid = 1'b1; axi.rid = '0; axi.rdata = 32'hdead; axi.rresp = '0; axi.rlast = 1'b0;
    repeat (2) @(negedge aclk);
    chk("reset_ctl", {cmd_ready, wr_ready, axi.awvalid, axi.wvalid, axi.wlast, axi.arvalid,
                      axi.bready, axi.rready, rd_valid, done_valid, timeout_err}, 64'd0);
    chk("reset_pay", {axi.awaddr, axi.araddr, axi.wdata, rd_data, done_id, done_resp}, 64'd0);
    areset = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0; axi.bvalid = 1'b0; axi.rvalid = 1'b0;
    #1 chk("bready_pre", axi.bready, 1'b0);
    @(negedge aclk);
    chk("bready_rise", axi.bready, 1'b1);

    // Write: 4 beats, awready two cycles late.
    send_cmd(1'b1, 4'd2, 32'h100, 8'd3);
    b = 0;
    for (int c = 1; c <= 10 && b < 4; c++) begin
      axi.awready = (c == 3);
      wr_valid = 1'b1; wr_data = 32'hA0 + b;
      #1;
      if (c == 1) chk("aw_issue", {axi.awvalid, axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst},
                      {1'b1, 4'd2, 32'h100, 8'd3, 3'd2, 2'b01});
      if (c == 4) chk("aw_drop", axi.awvalid, 1'b0);
      if (axi.wvalid && wr_ready) begin
        chk("wlast", {axi.wlast, axi.wdata}, {b == 3, 32'hA0 + b});
        b++;
      end
      @(negedge aclk);
    end
    wr_valid = 1'b0; axi.awready = 1'b1;
    chk("w_beats", b, 4);
    axi.bvalid = 1'b1; axi.bid = 4'd2; axi.bresp = 2'b00;
    #1 chk("b_pre_done", {axi.bready, done_valid}, 2'b10);
    @(negedge aclk);
    axi.bvalid = 1'b0;
    chk_done("wr_done", 1'b1, 4'd2, 2'b00, 1'b0);

    // Read len=1, OKAY then SLVERR with rlast.
    axi.arready = 1'b1;
    send_cmd(1'b0, 4'd5, 32'h200, 8'd1);
    chk("ar_issue", {axi.arvalid, axi.arid, axi.araddr, axi.arlen}, {1'b1, 4'd5, 32'h200, 8'd1});
    r_beat(4'd5, 32'h11, 2'b00, 1'b0);
    r_beat(4'd5, 32'h22, 2'b10, 1'b1);
    chk_done("rd_worst", 1'b0, 4'd5, 2'b10, 1'b0);

    // Early RLAST, then missing RLAST.
    send_cmd(1'b0, 4'd6, 32'h240, 8'd3);
    r_beat(4'd6, 32'h31, 2'b00, 1'b0);
    r_beat(4'd6, 32'h32, 2'b00, 1'b1);
    chk_done("rd_early", 1'b0, 4'd6, 2'b00, 1'b1);
    send_cmd(1'b0, 4'd7, 32'h280, 8'd1);
    r_beat(4'd7, 32'h41, 2'b00, 1'b0);
    r_beat(4'd7, 32'h42, 2'b01, 1'b0);
    chk_done("rd_nolast", 1'b0, 4'd7, 2'b01, 1'b1);

    // Fill all four slots, then check outstanding and duplicate-ID stalls.
    for (int i = 0; i < 4; i++) send_cmd(1'b0, 4'(i), 32'h1000 + 32'(i * 16), 8'd0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_id = 4'd8; cmd_len = 8'd0;
    for (int i = 0; i < 3; i++) begin #1 chk("full_stall", cmd_ready, 1'b0); @(negedge aclk); end
    r_beat(4'd0, 32'h50, 2'b00, 1'b1);
    chk_done("rd_slot0", 1'b0, 4'd0, 2'b00, 1'b0);
    cmd_id = 4'd1;
    #1 chk("dup_id", cmd_ready, 1'b0);
    cmd_id = 4'd8;
    #1 chk("freed", cmd_ready, 1'b1);
    @(negedge aclk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_beat((i == 3) ? 4'd8 : 4'(i + 1), 32'h60 + 32'(i), 2'b00, 1'b1);
      chk_done("rd_drain", 1'b0, (i == 3) ? 4'd8 : 4'(i + 1), 2'b00, 1'b0);
    end

    // B and final R in the same cycle.
    send_cmd(1'b1, 4'd3, 32'h300, 8'd0);
    wr_valid = 1'b1; wr_data = 32'h55; n = 0;
    #1;
    while (!wr_ready && n < 10) begin @(negedge aclk); #1; n++; end
    chk("w_single", {wr_ready, axi.wlast}, 2'b11);
    @(negedge aclk);
    wr_valid = 1'b0;
    send_cmd(1'b0, 4'd4, 32'h400, 8'd0);
    axi.bvalid = 1'b1; axi.bid = 4'd3; axi.bresp = 2'b00;
    axi.rvalid = 1'b1; axi.rid = 4'd4; axi.rresp = 2'b00; axi.rlast = 1'b1;
    #1 chk("b_r_ready", {axi.bready, axi.rready}, 2'b11);
    @(negedge aclk);
    axi.bvalid = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    chk_done("b_first", 1'b1, 4'd3, 2'b00, 1'b0);
    chk("skid_stall", {axi.bready, axi.rready}, 2'b00);
    @(negedge aclk);
    chk_done("r_skid", 1'b0, 4'd4, 2'b00, 1'b0);
    chk("ready_back", {axi.bready, axi.rready}, 2'b11);

    r_beat(4'd9, 32'h99, 2'b01, 1'b1);
    chk_done("stray_rid", 1'b0, 4'd9, 2'b01, 1'b1);

    // Reset mid-operation with AW held.
    axi.awready = 1'b0;
    send_cmd(1'b1, 4'd1, 32'h500, 8'd1);
    chk("aw_hold", axi.awvalid, 1'b1);
    areset = 1'b1; cmd_valid = 1'b1; wr_valid = 1'b1; axi.bvalid = 1'b1; axi.rvalid = 1'b1;
    @(negedge aclk);
    chk("mid_reset", {cmd_ready, wr_ready, axi.awvalid, axi.wvalid, axi.wlast, axi.arvalid,
                      axi.bready, axi.rready, rd_valid, done_valid, axi.awaddr}, 64'd0);
    areset = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0; axi.bvalid = 1'b0; axi.rvalid = 1'b0;
    @(negedge aclk);
    chk("post_reset", {axi.bready, axi.awvalid, done_valid}, 3'b100);

    // Watchdog: AW stalled well past the limit.
    send_cmd(1'b1, 4'd1, 32'h600, 8'd0);
    repeat (1005) @(negedge aclk);
    chk("aw_stuck", axi.awvalid, 1'b1);
`ifdef AXI4_MST_ENGINE_TIMEOUT_EN
    chk("timeout_aw", timeout_err[0], 1'b1);
`else
    chk("timeout_off", timeout_err, 4'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_master_burst_engine.md
# axi4_master_burst_engine

Synthesizable AXI4 master engine for RTL-integration benches. A simple command stream goes in; the engine issues AW/W/AR, collects B/R, and returns one completion per command. It supports up to MAX_OUTSTANDING concurrent transactions, a decoupled write-data FIFO, per-ID read length checking and response aggregation. It sits between a sequence-driven command source and the DUT's AXI4 slave port.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (8..1024, power of 2)
- ID_WIDTH, 4, ID width
- MAX_OUTSTANDING, 4, total in-flight commands (reads + writes), power of 2, ≥2
- TIMEOUT_CYCLES, 1000, watchdog limit (macro only)

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_id / cmd_addr / cmd_len / cmd_size / cmd_burst  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  burst fields
- wr_valid / wr_ready  in / out  1  write-data stream handshake
- wr_data / wr_strb  in  DATA_WIDTH / DATA_WIDTH/8  write beat
- awid, awaddr, awlen, awsize, awburst, awvalid  out  AXI4 widths  AW channel; awready in
- wdata, wstrb, wlast, wvalid  out  AXI4 widths  W channel; wready in
- bid, bresp, bvalid  in  ID_WIDTH / 2 / 1  B channel; bready out
- arid, araddr, arlen, arsize, arburst, arvalid  out  AXI4 widths  AR channel; arready in
- rid, rdata, rresp, rlast, rvalid  in  AXI4 widths  R channel; rready out
- rd_valid / rd_ready  out / in  1  read-data stream; rd_data, rd_resp, rd_id, rd_last mirror R
- done_valid  out  1  one-cycle completion pulse; done_write, done_id, done_resp[1:0], done_err out
- timeout_err  out  4  sticky {RESP, AR, W, AW} watchdog flags

## Operation
- The AXI4 fields not listed here (lock, cache, prot, qos, region) are not generated; the integration ties them to 0.
- Command accept requires all of:
  - inflight < MAX_OUTSTANDING;
  - the target address register (AW or AR) is empty;
  - for reads, cmd_id does not match any in-flight read ID;
  - for writes, the W length FIFO is not full.
- Write command:
  - latch into the AW register; awvalid asserts the next cycle and holds with stable payload until awready;
  - push cmd_len into the W length FIFO (depth MAX_OUTSTANDING).
- W FSM:
  - W_IDLE: pop the FIFO when it is non-empty, then go to W_BEAT.
  - W_BEAT: wvalid = wr_valid, wr_ready = wready, wdata/wstrb pass through, wlast = (beat_cnt == len). On handshake with wlast, go to W_IDLE; otherwise beat_cnt++.
  - W may lead AW acceptance.
- B: bready = !skid_full. On handshake, the completion is done_write=1, done_id=bid, done_resp=bresp, done_err=0.
- Read command: latch into the AR register, same hold rules as AW. Allocate a table entry {id, len, cnt=0, worst_resp=0}.
- R:
  - rready = rd_ready && !skid_full; R beats forward to rd_* combinationally.
  - Each beat does cnt++ and worst_resp = max(worst_resp, rresp) in the entry matching rid.
  - The entry completes on rlast or when cnt reaches len+1, whichever comes first.
  - done_err=1 if those two events do not coincide (early or missing RLAST).
  - An rid with no matching entry gives done_err=1 with done_id=rid, and does not change inflight.
- Completion priority per cycle: skid register > B > R. If B and a final R handshake coincide, R goes to the 1-entry skid and is reported the next cycle.
- inflight increments on command accept and decrements on completion. Both in the same cycle leave it unchanged.
- Reset mid-operation: all FIFOs, table entries, counters and registers clear. In-flight transactions are abandoned with no completion.

## Timing
- Reset values: cmd_ready, wr_ready, awvalid, wvalid, wlast, arvalid, bready, rready, rd_valid, done_valid = 0; timeout_err = 0; all payload outputs = 0.
- bready rises the first cycle after areset deasserts.
- Command accept to awvalid/arvalid: 1 cycle. There is no combinational path from cmd_* to AW/AR.
- B or final-R handshake to done_valid: 1 cycle, registered; 2 cycles when routed through the skid.
- Back-to-back commands are accepted every cycle while the accept conditions hold. A full AW register frees in the cycle awready is seen.

## Configuration
- AXI4_MST_ENGINE_TIMEOUT_EN defined:
  - per-channel counters count cycles with valid && !ready for AW, W and AR;
  - the RESP counter counts cycles with inflight > 0 and no B/R handshake;
  - reaching TIMEOUT_CYCLES sets the sticky timeout_err bit, cleared only by reset;
  - valids are never dropped.
- Macro undefined: no counters; timeout_err is tied to 4'b0.

## Test plan
- Write id=2, addr=0x100, len=3, size=2, INCR; wr stream of 4 beats; awready 2 cycles late -> wlast only on beat 4; done_write=1, done_id=2, done_resp=OKAY one cycle after B.
- Read id=5, len=1; slave returns rresp OKAY then SLVERR with rlast -> rd_* gives 2 beats; done_resp=2'b10, done_err=0.
- Read len=3 with rlast on beat 2 -> completes early, done_err=1. Read len=1 without rlast -> completes after 2 beats, done_err=1.
- Issue MAX_OUTSTANDING=4 reads with ids 0..3 and no slave responses -> 5th command sees cmd_ready=0 until the first completion. Duplicate read id -> stalled.
- B and final R handshake in the same cycle -> B done at T+1, R done at T+2; bready and rready low at T+1.
- With macro: awready held 0 for 1000 cycles -> timeout_err[0]=1, awvalid stays 1. Without macro: timeout_err stays 0.
